// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle multiply/divide unit beside the EXE-stage ALU.
// Owns architectural HI/LO and commits them only when the owning instruction
// leaves EXE unflushed.
//
// Handshake: EXE_MDUBusy is a combinational stall request. While it is high the
// hazard unit must hold the instruction in EXE. Once the result is ready
// (state DONE) busy is low, and the result is committed on the first edge where
// EXE_Advance=1 and EXE_Flush=0. EXE_Flush wins over EXE_Advance in every state.
module mdu_sequencer #(
    parameter int MUL_LAT  = 2,   // cycles spent in MUL (1..64)
    parameter int DIV_ITER = 32   // restoring-divider steps, fixed by 32-bit operands
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [2:0]  EXE_MDUOp,
    input  logic [31:0] EXE_ResultA,
    input  logic [31:0] EXE_ResultB,
    input  logic        EXE_Valid,
    input  logic        EXE_Flush,
    input  logic        EXE_Advance,
    output logic        EXE_MDUBusy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [1:0]  o_dbg_state
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [5:0] MUL_CNT_INIT = 6'(MUL_LAT - 1);
    localparam logic [5:0] DIV_CNT_INIT = 6'(DIV_ITER - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [31:0] r_a;        // multiplicand, or dividend shifting into quotient
    logic [31:0] r_b;        // multiplier, or |divisor|
    logic [31:0] r_rem;      // partial remainder
    logic        r_signed;   // MULT/DIV (as opposed to MULTU/DIVU)
    logic        r_neg_q;    // quotient needs negation
    logic        r_neg_r;    // remainder needs negation
    logic [5:0]  r_cnt;
    logic [31:0] r_res_hi;
    logic [31:0] r_res_lo;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_is_mul;
    logic        w_is_div;
    logic        w_op_signed;
    logic        w_start;
    logic        w_commit;
    logic        w_mt_ok;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [63:0] w_prod;
    logic [32:0] w_rem_shift;
    logic        w_take;
    logic [31:0] w_rem_next;
    logic [31:0] w_q_next;

    assign w_is_mul    = (EXE_MDUOp == OP_MULT) || (EXE_MDUOp == OP_MULTU);
    assign w_is_div    = (EXE_MDUOp == OP_DIV)  || (EXE_MDUOp == OP_DIVU);
    assign w_op_signed = (EXE_MDUOp == OP_MULT) || (EXE_MDUOp == OP_DIV);
    assign w_start     = (r_state == S_IDLE) && EXE_Valid && !EXE_Flush && (w_is_mul || w_is_div);
    assign w_commit    = (r_state == S_DONE) && EXE_Advance && !EXE_Flush;
    assign w_mt_ok     = (r_state == S_IDLE) && EXE_Valid && EXE_Advance && !EXE_Flush;

    // resetn gating keeps the stall low even if a start pattern sits on the inputs during reset
    assign EXE_MDUBusy = resetn && !EXE_Flush &&
                         (w_start || (r_state == S_MUL) || (r_state == S_DIV));

    // Magnitudes for the signed divide; unsigned ops pass the raw operands
    assign w_abs_a = (w_op_signed && EXE_ResultA[31]) ? (~EXE_ResultA + 32'd1) : EXE_ResultA;
    assign w_abs_b = (w_op_signed && EXE_ResultB[31]) ? (~EXE_ResultB + 32'd1) : EXE_ResultB;

    // Low 64 bits of the extended product are the exact signed or unsigned result
    assign w_prod = r_signed ? ({{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b})
                             : ({32'd0, r_a} * {32'd0, r_b});

    // One restoring step. With a zero divisor every step subtracts nothing,
    // which naturally yields quotient all-ones and remainder = dividend.
    assign w_rem_shift = {r_rem, r_a[31]};
    assign w_take      = (w_rem_shift >= {1'b0, r_b});
    assign w_rem_next  = w_take ? (w_rem_shift[31:0] - r_b) : w_rem_shift[31:0];
    assign w_q_next    = {r_a[30:0], w_take};

    assign HI          = r_hi;
    assign LO          = r_lo;
    assign o_dbg_state = r_state;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; flush always returns to IDLE before anything else
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_next = w_is_mul ? S_MUL : S_DIV;
                end
            end
            S_MUL, S_DIV: begin
                if (EXE_Flush) begin
                    w_state_next = S_IDLE;
                end else if (r_cnt == 6'd0) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (EXE_Flush || EXE_Advance) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Operand capture, iteration and result latching
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_rem    <= 32'd0;
            r_signed <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_cnt    <= 6'd0;
            r_res_hi <= 32'd0;
            r_res_lo <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_signed <= w_op_signed;
                        r_rem    <= 32'd0;
                        if (w_is_div) begin
                            r_a     <= w_abs_a;
                            r_b     <= w_abs_b;
                            r_neg_q <= w_op_signed && (EXE_ResultA[31] ^ EXE_ResultB[31]);
                            r_neg_r <= w_op_signed && EXE_ResultA[31];
                            r_cnt   <= DIV_CNT_INIT;
                        end else begin
                            r_a     <= EXE_ResultA;
                            r_b     <= EXE_ResultB;
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                            r_cnt   <= MUL_CNT_INIT;
                        end
                    end
                end
                S_MUL: begin
                    if (!EXE_Flush) begin
                        if (r_cnt == 6'd0) begin
                            r_res_hi <= w_prod[63:32];
                            r_res_lo <= w_prod[31:0];
                        end else begin
                            r_cnt <= r_cnt - 6'd1;
                        end
                    end
                end
                S_DIV: begin
                    if (!EXE_Flush) begin
                        r_rem <= w_rem_next;
                        r_a   <= w_q_next;
                        if (r_cnt == 6'd0) begin
                            r_res_lo <= r_neg_q ? (~w_q_next + 32'd1) : w_q_next;
                            r_res_hi <= r_neg_r ? (~w_rem_next + 32'd1) : w_rem_next;
                        end else begin
                            r_cnt <= r_cnt - 6'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Architectural HI/LO: written only by a commit or an MTHI/MTLO that advances
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_commit) begin
            r_hi <= r_res_hi;
            r_lo <= r_res_lo;
        end else if (w_mt_ok) begin
            if (EXE_MDUOp == OP_MTHI) begin
                r_hi <= EXE_ResultA;
            end
            if (EXE_MDUOp == OP_MTLO) begin
                r_lo <= EXE_ResultA;
            end
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Bench for mdu_sequencer: directed cases plus randomized mult/div traffic
// checked against an arithmetic reference model.
module tb_mdu_sequencer;

  localparam int MUL_LAT  = 2;
  localparam int DIV_ITER = 32;
  localparam logic [1:0] DBG_IDLE = 2'd0;
  localparam logic [1:0] DBG_DONE = 2'd3;

  logic        clk;
  logic        resetn;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        valid;
  logic        flush;
  logic        adv;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [1:0]  dbg_state;

  int          n_vec;
  int          n_err;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  mdu_sequencer #(.MUL_LAT(MUL_LAT), .DIV_ITER(DIV_ITER)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .EXE_MDUOp   (op),
    .EXE_ResultA (a),
    .EXE_ResultB (b),
    .EXE_Valid   (valid),
    .EXE_Flush   (flush),
    .EXE_Advance (adv),
    .EXE_MDUBusy (busy),
    .HI          (hi),
    .LO          (lo),
    .o_dbg_state (dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: returns {HI, LO} from plain arithmetic
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    res = 64'd0;
    case (o)
      3'd1: begin
        q = sx * sy;
        res = q;
      end
      3'd2: res = {32'd0, x} * {32'd0, y};
      3'd3: begin
        if (y == 32'd0) begin
          q = 64'hFFFF_FFFF;
          r = (sx < 0) ? -sx : sx;
          if (x[31]) q = -q;
          if (x[31]) r = -r;
        end else begin
          q = sx / sy;
          r = sx % sy;
        end
        res = {r[31:0], q[31:0]};
      end
      3'd4: begin
        if (y == 32'd0) res = {x, 32'hFFFF_FFFF};
        else res = {x % y, x / y};
      end
      default: res = {exp_hi, exp_lo};
    endcase
    return res;
  endfunction

  task automatic idle_inputs();
    op = 3'd0; a = 32'd0; b = 32'd0; valid = 1'b0; flush = 1'b0; adv = 1'b0;
  endtask

  // issue one mult/div, hold DONE for 'hold' cycles, then advance and check commit
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input int hold);
    logic [63:0] m;
    int busy_cnt;
    int exp_busy;
    m = model(o, x, y);
    exp_busy = (o == 3'd1 || o == 3'd2) ? 1 + MUL_LAT : 1 + DIV_ITER;
    @(posedge clk); #1;
    op = o; a = x; b = y; valid = 1'b1; flush = 1'b0; adv = 1'b0;
    busy_cnt = 0;
    @(negedge clk);
    while (busy === 1'b1 && busy_cnt < 100) begin
      busy_cnt++;
      @(posedge clk); #1;
      a = $urandom; b = $urandom;   // operands must be ignored after start
      @(negedge clk);
    end
    n_vec++;
    if (busy_cnt != exp_busy) begin
      n_err++;
      $display("FAIL busy_len op=%0d: got %0d cycles, expected %0d", o, busy_cnt, exp_busy);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      n_vec++;
      if (busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo || dbg_state !== DBG_DONE) begin
        n_err++;
        $display("FAIL done_hold: busy=%b hi=%h lo=%h st=%0d, expected busy=0 hi=%h lo=%h st=%0d",
                 busy, hi, lo, dbg_state, exp_hi, exp_lo, DBG_DONE);
      end
    end
    adv = 1'b1;
    @(posedge clk); #1;
    idle_inputs();
    exp_hi = m[63:32];
    exp_lo = m[31:0];
    @(negedge clk);
    n_vec++;
    if (hi !== exp_hi || lo !== exp_lo || dbg_state !== DBG_IDLE) begin
      n_err++;
      $display("FAIL commit op=%0d a=%h b=%h: hi=%h lo=%h st=%0d, expected hi=%h lo=%h st=0",
               o, x, y, hi, lo, dbg_state, exp_hi, exp_lo);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    idle_inputs();
    op = 3'd1; valid = 1'b1; a = 32'd5; b = 32'd6;
    exp_hi = 32'd0; exp_lo = 32'd0;
    #12;
    n_vec++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || dbg_state !== DBG_IDLE) begin
      n_err++;
      $display("FAIL reset: busy=%b hi=%h lo=%h st=%0d, expected 0 0 0 0", busy, hi, lo, dbg_state);
    end
    idle_inputs();
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_directed();
    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 0);
    run_op(3'd2, 32'hFFFF_FFFE, 32'd3, 0);
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1);
    run_op(3'd4, 32'd7, 32'd0, 0);
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(3'd3, 32'hFFFF_FFFB, 32'd0, 0);
  endtask

  task automatic test_done_hold();
    run_op(3'd2, 32'h1234_5678, 32'h9ABC_DEF0, 3);
  endtask

  task automatic test_done_flush();
    @(posedge clk); #1;
    op = 3'd1; a = 32'd1000; b = 32'd1000; valid = 1'b1;
    repeat (1 + MUL_LAT) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL done_flush_busy: got %b expected 0", busy);
    end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    n_vec++;
    if (hi !== exp_hi || lo !== exp_lo || dbg_state !== DBG_IDLE) begin
      n_err++;
      $display("FAIL done_flush: hi=%h lo=%h st=%0d, expected hi=%h lo=%h st=0", hi, lo, dbg_state, exp_hi, exp_lo);
    end
  endtask

  task automatic test_div_flush();
    @(posedge clk); #1;
    op = 3'd3; a = 32'hDEAD_BEEF; b = 32'd17; valid = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL div_busy_before_flush: got %b expected 1", busy);
    end
    flush = 1'b1;
    #1;
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL div_flush_busy: got %b expected 0", busy);
    end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    n_vec++;
    if (hi !== exp_hi || lo !== exp_lo || dbg_state !== DBG_IDLE) begin
      n_err++;
      $display("FAIL div_flush: hi=%h lo=%h st=%0d, expected hi=%h lo=%h st=0", hi, lo, dbg_state, exp_hi, exp_lo);
    end
    run_op(3'd4, 32'd100, 32'd7, 0);
  endtask

  // MTHI/MTLO writes, plus non-writing variants (no advance, flush, bubble, op 7)
  task automatic test_mt();
    logic [2:0]  ops  [6] = '{3'd5, 3'd6, 3'd5, 3'd6, 3'd5, 3'd7};
    logic [31:0] vals [6] = '{32'h1234_5678, 32'h0BAD_F00D, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    logic        advs [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic        fls  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        vls  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      op = ops[i]; a = vals[i]; b = $urandom; adv = advs[i]; flush = fls[i]; valid = vls[i];
      @(negedge clk);
      n_vec++;
      if (busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
        n_err++;
        $display("FAIL mt_pre[%0d]: busy=%b hi=%h lo=%h, expected busy=0 hi=%h lo=%h", i, busy, hi, lo, exp_hi, exp_lo);
      end
      if (advs[i] && !fls[i] && vls[i]) begin
        if (ops[i] == 3'd5) exp_hi = vals[i];
        if (ops[i] == 3'd6) exp_lo = vals[i];
      end
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      n_vec++;
      if (hi !== exp_hi || lo !== exp_lo) begin
        n_err++;
        $display("FAIL mt_post[%0d]: hi=%h lo=%h, expected hi=%h lo=%h", i, hi, lo, exp_hi, exp_lo);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] corners [6] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd2};
    logic [31:0] x, y;
    for (int i = 0; i < 30; i++) begin
      x = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : 32'($urandom);
      y = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : 32'($urandom);
      if ($urandom_range(0, 1) == 1) y = y >> $urandom_range(0, 31);
      run_op(3'($urandom_range(1, 4)), x, y, $urandom_range(0, 2));
    end
  endtask

  task automatic test_reset_mid_mul();
    @(posedge clk); #1;
    op = 3'd1; a = 32'd12345; b = 32'd678; valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL mul_busy_before_reset: got %b expected 1", busy);
    end
    #2;
    resetn = 1'b0;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    #1;
    n_vec++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_err++;
      $display("FAIL reset_mid_mul: busy=%b hi=%h lo=%h, expected 0 0 0", busy, hi, lo);
    end
    idle_inputs();
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    n_vec++;
    if (dbg_state !== DBG_IDLE || busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_err++;
      $display("FAIL after_reset: st=%0d busy=%b hi=%h lo=%h, expected 0 0 0 0", dbg_state, busy, hi, lo);
    end
  endtask

  // busy must never rise during MTHI/MTLO traffic
  logic mt_phase;
  always @(negedge clk) begin
    if (mt_phase && busy === 1'b1) begin
      n_err++;
      $display("FAIL mt_busy: busy high during MTHI/MTLO sequence");
    end
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    mt_phase = 1'b0;
    test_reset();
    test_directed();
    test_done_hold();
    test_done_flush();
    test_div_flush();
    mt_phase = 1'b1;
    test_mt();
    mt_phase = 1'b0;
    test_random();
    run_op(3'd3, 32'd99, 32'd5, 0);
    test_reset_mid_mul();
    run_op(3'd4, 32'd100, 32'd7, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
